// File: rtl/z80_pkg.sv
// Shared definitions for the Z80 register bank: register indices, pair
// encoding and the helpers that map a pair onto its two byte registers.
package z80_pkg;

  localparam int REG_A = 0;
  localparam int REG_F = 1;
  localparam int REG_B = 2;
  localparam int REG_C = 3;
  localparam int REG_D = 4;
  localparam int REG_E = 5;
  localparam int REG_H = 6;
  localparam int REG_L = 7;

  // Number of registers that exist in both the main and alternate bank
  localparam int NBANKED = 8;

  localparam logic [7:0] A_RST_BYTE = 8'hFF;
  localparam logic [7:0] F_RST_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_AF = 2'd3
  } pair_t;

  // High byte of a pair is the first-named register
  function automatic int pair_hi(input pair_t p);
    case (p)
      PAIR_BC: return REG_B;
      PAIR_DE: return REG_D;
      PAIR_HL: return REG_H;
      PAIR_AF: return REG_A;
      default: return REG_A;
    endcase
  endfunction

  function automatic int pair_lo(input pair_t p);
    case (p)
      PAIR_BC: return REG_C;
      PAIR_DE: return REG_E;
      PAIR_HL: return REG_L;
      PAIR_AF: return REG_F;
      default: return REG_F;
    endcase
  endfunction

endpackage

// File: rtl/z80_regbank_if.sv
// Access bus between the control FSM / datapath (master) and the register
// bank (slave): read and write ports, exchange strobes and status.
interface z80_regbank_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [AW-1:0]   rd_a_sel;
  logic [DW-1:0]   rd_a_data;
  logic [AW-1:0]   rd_b_sel;
  logic [DW-1:0]   rd_b_data;
  logic [1:0]      rd_pair_sel;
  logic [2*DW-1:0] rd_pair_data;
  logic            wr_en;
  logic [AW-1:0]   wr_sel;
  logic [DW-1:0]   wr_data;
  logic            wr_pair_en;
  logic [1:0]      wr_pair_sel;
  logic [2*DW-1:0] wr_pair_data;
  logic            flag_wr_en;
  logic [DW-1:0]   flag_data;
  logic            ex_af;
  logic            exx;
  logic            ex_de_hl;
  logic [DW-1:0]   a_out;
  logic [DW-1:0]   f_out;
  logic            bank_af;
  logic            bank_main;
  logic            conflict;

  modport master (
    output rd_a_sel, rd_b_sel, rd_pair_sel,
           wr_en, wr_sel, wr_data,
           wr_pair_en, wr_pair_sel, wr_pair_data,
           flag_wr_en, flag_data,
           ex_af, exx, ex_de_hl,
    input  rd_a_data, rd_b_data, rd_pair_data,
           a_out, f_out, bank_af, bank_main, conflict
  );

  modport slave (
    input  rd_a_sel, rd_b_sel, rd_pair_sel,
           wr_en, wr_sel, wr_data,
           wr_pair_en, wr_pair_sel, wr_pair_data,
           flag_wr_en, flag_data,
           ex_af, exx, ex_de_hl,
    output rd_a_data, rd_b_data, rd_pair_data,
           a_out, f_out, bank_af, bank_main, conflict
  );
endinterface

// File: rtl/z80_reg_bank.sv
// One physical bank of the eight banked Z80 registers (A,F,B,C,D,E,H,L) with
// a per-register write enable; all priority decisions are made by the caller.
module z80_reg_bank
  import z80_pkg::*;
#(
  parameter int            DW    = 8,
  parameter logic [DW-1:0] A_RST = '1,
  parameter logic [DW-1:0] F_RST = '1
) (
  input  logic                  clk,
  input  logic                  rst_L,
  input  logic [7:0]            we,
  input  logic [7:0][DW-1:0]    wd,
  output logic [7:0][DW-1:0]    q
);

  // Register storage with reset values for A and F
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      for (int i = 0; i < NBANKED; i++) begin
        if (i == REG_A) begin
          q[i] <= A_RST;
        end else if (i == REG_F) begin
          q[i] <= F_RST;
        end else begin
          q[i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NBANKED; i++) begin
        if (we[i]) begin
          q[i] <= wd[i];
        end
      end
    end
  end

endmodule

// File: rtl/z80_regbank.sv
// Z80 register file with main/alternate banks selected by pointer bits,
// unbanked extension registers, and same-cycle write/exchange arbitration.
module z80_regbank
  import z80_pkg::*;
#(
  parameter int            DW    = 8,
  parameter int            NREG  = 8,
  parameter logic [DW-1:0] A_RST = '1,
  parameter logic [DW-1:0] F_RST = '1
) (
  input  logic          clk,
  input  logic          rst_L,
  z80_regbank_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic                bank_af_r;
  logic                bank_main_r;
  logic                conflict_r;

  logic [7:0]          bank_sel_s;
  logic [7:0][DW-1:0]  main_q_s;
  logic [7:0][DW-1:0]  alt_q_s;
  logic [7:0]          main_we_s;
  logic [7:0]          alt_we_s;
  logic [7:0][DW-1:0]  bank_wd_s;

  logic [DW-1:0]       view_s [NREG];
  logic [DW-1:0]       swp_s  [NREG];
  logic [NREG-1:0]     reg_we_s;
  logic [DW-1:0]       reg_wd_s [NREG];

  pair_t               wr_pair_s;
  int                  pair_hi_s;
  int                  pair_lo_s;
  logic                byte_oor_s;
  logic                drop_byte_s;
  logic                drop_pair_s;
  logic                byte_ok_s;
  logic                pair_ok_s;
  logic                conflict_s;

  logic [DW-1:0]       rd_a_s;
  logic [DW-1:0]       rd_b_s;
  logic [2*DW-1:0]     rd_pair_s;

  // Logical view: A/F follow bank_af, B..L follow bank_main
  for (genvar i = 0; i < NBANKED; i++) begin : g_view
    assign bank_sel_s[i] = (i < 2) ? bank_af_r : bank_main_r;
    assign view_s[i]     = bank_sel_s[i] ? alt_q_s[i] : main_q_s[i];
  end

  z80_reg_bank #(.DW(DW), .A_RST(A_RST), .F_RST(F_RST)) u_main (
    .clk   (clk),
    .rst_L (rst_L),
    .we    (main_we_s),
    .wd    (bank_wd_s),
    .q     (main_q_s)
  );

  z80_reg_bank #(.DW(DW), .A_RST(A_RST), .F_RST(F_RST)) u_alt (
    .clk   (clk),
    .rst_L (rst_L),
    .we    (alt_we_s),
    .wd    (bank_wd_s),
    .q     (alt_q_s)
  );

  // Unbanked extension registers, reachable only by byte writes
  if (NREG > NBANKED) begin : g_extra
    logic [DW-1:0] q_r [NREG-NBANKED];

    for (genvar k = 0; k < NREG - NBANKED; k++) begin : g_view
      assign view_s[NBANKED+k] = q_r[k];
    end

    // Extension register storage
    always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
        for (int k = 0; k < NREG - NBANKED; k++) begin
          q_r[k] <= '0;
        end
      end else begin
        for (int k = 0; k < NREG - NBANKED; k++) begin
          if (reg_we_s[NBANKED+k]) begin
            q_r[k] <= reg_wd_s[NBANKED+k];
          end
        end
      end
    end
  end

  // Write qualification: EX DE,HL kills any write touching D/E/H/L
  always_comb begin
    wr_pair_s   = pair_t'(bus.wr_pair_sel);
    pair_hi_s   = pair_hi(wr_pair_s);
    pair_lo_s   = pair_lo(wr_pair_s);
    byte_oor_s  = bus.wr_en && (32'(bus.wr_sel) >= 32'(NREG));
    drop_byte_s = bus.wr_en && bus.ex_de_hl &&
                  (bus.wr_sel >= AW'(REG_D)) && (bus.wr_sel <= AW'(REG_L));
    drop_pair_s = bus.wr_pair_en && bus.ex_de_hl &&
                  ((wr_pair_s == PAIR_DE) || (wr_pair_s == PAIR_HL));
    byte_ok_s   = bus.wr_en && !byte_oor_s && !drop_byte_s;
    pair_ok_s   = bus.wr_pair_en && !drop_pair_s;
    conflict_s  = byte_oor_s || drop_byte_s || drop_pair_s;
  end

  // Swap sources for EX DE,HL taken from the pre-edge active bank
  always_comb begin
    swp_s        = view_s;
    swp_s[REG_D] = view_s[REG_H];
    swp_s[REG_E] = view_s[REG_L];
    swp_s[REG_H] = view_s[REG_D];
    swp_s[REG_L] = view_s[REG_E];
  end

  // Per logical register priority: byte, pair, flag, swap, hold
  always_comb begin
    reg_we_s = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_wd_s[i] = view_s[i];
      if (byte_ok_s && (bus.wr_sel == AW'(i))) begin
        reg_we_s[i] = 1'b1;
        reg_wd_s[i] = bus.wr_data;
      end else if (pair_ok_s && (i == pair_hi_s)) begin
        reg_we_s[i] = 1'b1;
        reg_wd_s[i] = bus.wr_pair_data[2*DW-1:DW];
      end else if (pair_ok_s && (i == pair_lo_s)) begin
        reg_we_s[i] = 1'b1;
        reg_wd_s[i] = bus.wr_pair_data[DW-1:0];
      end else if (bus.flag_wr_en && (i == REG_F)) begin
        reg_we_s[i] = 1'b1;
        reg_wd_s[i] = bus.flag_data;
      end else if (bus.ex_de_hl && (i >= REG_D) && (i <= REG_L)) begin
        reg_we_s[i] = 1'b1;
        reg_wd_s[i] = swp_s[i];
      end else begin
        reg_we_s[i] = 1'b0;
      end
    end
  end

  // Route logical writes to the physical bank chosen by pre-edge pointers
  always_comb begin
    for (int i = 0; i < NBANKED; i++) begin
      main_we_s[i] = reg_we_s[i] & ~bank_sel_s[i];
      alt_we_s[i]  = reg_we_s[i] &  bank_sel_s[i];
      bank_wd_s[i] = reg_wd_s[i];
    end
  end

  // Bank pointers and the one-cycle conflict pulse
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      bank_af_r   <= 1'b0;
      bank_main_r <= 1'b0;
      conflict_r  <= 1'b0;
    end else begin
      bank_af_r   <= bank_af_r ^ bus.ex_af;
      bank_main_r <= bank_main_r ^ bus.exx;
      conflict_r  <= conflict_s;
    end
  end

  // Byte read ports; out-of-range selects read as zero
  always_comb begin
    rd_a_s = '0;
    rd_b_s = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.rd_a_sel == AW'(i)) begin
        rd_a_s = view_s[i];
      end else begin
        rd_a_s = rd_a_s;
      end
      if (bus.rd_b_sel == AW'(i)) begin
        rd_b_s = view_s[i];
      end else begin
        rd_b_s = rd_b_s;
      end
    end
  end

  // Pair read port
  always_comb begin
    case (pair_t'(bus.rd_pair_sel))
      PAIR_BC: rd_pair_s = {view_s[REG_B], view_s[REG_C]};
      PAIR_DE: rd_pair_s = {view_s[REG_D], view_s[REG_E]};
      PAIR_HL: rd_pair_s = {view_s[REG_H], view_s[REG_L]};
      PAIR_AF: rd_pair_s = {view_s[REG_A], view_s[REG_F]};
      default: rd_pair_s = '0;
    endcase
  end

  assign bus.rd_a_data    = rd_a_s;
  assign bus.rd_b_data    = rd_b_s;
  assign bus.rd_pair_data = rd_pair_s;
  assign bus.a_out        = view_s[REG_A];
  assign bus.f_out        = view_s[REG_F];
  assign bus.bank_af      = bank_af_r;
  assign bus.bank_main    = bank_main_r;
  assign bus.conflict     = conflict_r;

endmodule

// File: tb/tb_z80_regbank.sv
// Directed bench for z80_regbank (NREG = 12). The reference model moves data on
// every exchange, as the real CPU does, and is compared on each falling edge.
module tb_z80_regbank;
  import z80_pkg::*;

  localparam int DW   = 8;
  localparam int NREG = 12;
  localparam int AW   = 4;

  logic clk;
  logic rst_L;

  z80_regbank_if #(.DW(DW), .AW(AW)) bus ();

  z80_regbank #(.DW(DW), .NREG(NREG), .A_RST(8'hFF), .F_RST(8'hFF)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: cur holds the active registers, shd the inactive set
  logic [7:0] cur   [NREG];
  logic [7:0] shd   [8];
  logic [7:0] n_cur [NREG];
  logic [7:0] n_shd [8];
  logic       m_baf, m_bm, m_conf;
  logic       n_baf, n_bm, n_conf;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act === want) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) cur[i] = 8'h00;
    for (int i = 0; i < 8; i++) shd[i] = 8'h00;
    cur[0] = 8'hFF; cur[1] = 8'hFF;
    shd[0] = 8'hFF; shd[1] = 8'hFF;
    m_baf = 1'b0; m_bm = 1'b0; m_conf = 1'b0;
  endtask

  function automatic logic [7:0] exp_read(input int s);
    if (s < NREG) return cur[s];
    return 8'h00;
  endfunction

  function automatic logic [15:0] exp_pair(input logic [1:0] p);
    case (p)
      2'd0:    return {cur[2], cur[3]};
      2'd1:    return {cur[4], cur[5]};
      2'd2:    return {cur[6], cur[7]};
      default: return {cur[0], cur[1]};
    endcase
  endfunction

  task automatic model_step();
    int         s;
    int         hi;
    logic [7:0] t;
    bit         oor, drop_b, drop_p;
    n_cur = cur; n_shd = shd;
    n_baf = m_baf; n_bm = m_bm; n_conf = m_conf;
    if (rst_L !== 1'b1) return;
    s      = int'(bus.wr_sel);
    oor    = bus.wr_en && (s >= NREG);
    drop_b = bus.wr_en && bus.ex_de_hl && (s >= 4) && (s <= 7);
    drop_p = bus.wr_pair_en && bus.ex_de_hl && (bus.wr_pair_sel == 2'd1 || bus.wr_pair_sel == 2'd2);
    // lowest priority first so that later updates override
    if (bus.ex_de_hl) begin
      n_cur[4] = cur[6]; n_cur[5] = cur[7];
      n_cur[6] = cur[4]; n_cur[7] = cur[5];
    end
    if (bus.flag_wr_en) n_cur[1] = bus.flag_data;
    if (bus.wr_pair_en && !drop_p) begin
      case (bus.wr_pair_sel)
        2'd0:    hi = 2;
        2'd1:    hi = 4;
        2'd2:    hi = 6;
        default: hi = 0;
      endcase
      n_cur[hi]   = bus.wr_pair_data[15:8];
      n_cur[hi+1] = bus.wr_pair_data[7:0];
    end
    if (bus.wr_en && !oor && !drop_b) n_cur[s] = bus.wr_data;
    if (bus.ex_af) begin
      for (int i = 0; i < 2; i++) begin
        t = n_cur[i]; n_cur[i] = n_shd[i]; n_shd[i] = t;
      end
    end
    if (bus.exx) begin
      for (int i = 2; i < 8; i++) begin
        t = n_cur[i]; n_cur[i] = n_shd[i]; n_shd[i] = t;
      end
    end
    n_baf  = m_baf ^ bus.ex_af;
    n_bm   = m_bm ^ bus.exx;
    n_conf = oor || drop_b || drop_p;
  endtask

  task automatic clear_pulses();
    bus.wr_en = 1'b0; bus.wr_pair_en = 1'b0; bus.flag_wr_en = 1'b0;
    bus.ex_af = 1'b0; bus.exx = 1'b0; bus.ex_de_hl = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cur = n_cur; shd = n_shd;
    m_baf = n_baf; m_bm = n_bm; m_conf = n_conf;
    #1;
    clear_pulses();
  endtask

  task automatic sweep();
    for (int s = 0; s < 16; s++) begin
      bus.rd_a_sel    = 4'(s);
      bus.rd_b_sel    = 4'(15 - s);
      bus.rd_pair_sel = 2'(s);
      tick();
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_a",      16'(bus.rd_a_data), 16'(exp_read(int'(bus.rd_a_sel))));
      check("rd_b",      16'(bus.rd_b_data), 16'(exp_read(int'(bus.rd_b_sel))));
      check("rd_pair",   bus.rd_pair_data,   exp_pair(bus.rd_pair_sel));
      check("a_out",     16'(bus.a_out),     16'(cur[0]));
      check("f_out",     16'(bus.f_out),     16'(cur[1]));
      check("bank_af",   16'(bus.bank_af),   16'(m_baf));
      check("bank_main", 16'(bus.bank_main), 16'(m_bm));
      check("conflict",  16'(bus.conflict),  16'(m_conf));
    end
  end

  initial begin
    rst_L = 1'b0;
    bus.rd_a_sel = 4'd0; bus.rd_b_sel = 4'd0; bus.rd_pair_sel = 2'd0;
    bus.wr_sel = 4'd0; bus.wr_data = 8'h00;
    bus.wr_pair_sel = 2'd0; bus.wr_pair_data = 16'h0000;
    bus.flag_data = 8'h00;
    clear_pulses();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_L  = 1'b1;
    chk_en = 1'b1;
    check("rst_a",     16'(bus.a_out),     16'h00FF);
    check("rst_f",     16'(bus.f_out),     16'h00FF);
    check("rst_bc",    bus.rd_pair_data,   16'h0000);
    check("rst_baf",   16'(bus.bank_af),   16'h0000);
    check("rst_bmain", 16'(bus.bank_main), 16'h0000);
    sweep();

    // EX AF,AF' with writes on either side
    bus.rd_a_sel = 4'd0;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd0; bus.wr_data = 8'h12; tick();
    bus.ex_af = 1'b1; tick();
    bus.wr_en = 1'b1; bus.wr_sel = 4'd0; bus.wr_data = 8'h34; tick();
    bus.ex_af = 1'b1; tick();
    check("exaf_a_main", 16'(bus.a_out),   16'h0012);
    check("exaf_bank",   16'(bus.bank_af), 16'h0000);
    bus.ex_af = 1'b1; tick();
    check("exaf_a_alt",  16'(bus.a_out),   16'h0034);
    bus.ex_af = 1'b1; tick();

    // EXX hides HL; EX DE,HL moves it into DE
    bus.rd_pair_sel = 2'd2;
    bus.wr_pair_en = 1'b1; bus.wr_pair_sel = 2'd2; bus.wr_pair_data = 16'hBEEF; tick();
    bus.exx = 1'b1; tick();
    check("exx_hl_alt", bus.rd_pair_data, 16'h0000);
    bus.exx = 1'b1; tick();
    bus.ex_de_hl = 1'b1; tick();
    check("dehl_hl", bus.rd_pair_data, 16'h0000);
    bus.rd_pair_sel = 2'd1; #1;
    check("dehl_de", bus.rd_pair_data, 16'hBEEF);

    // EX DE,HL with a colliding byte write to D
    bus.wr_pair_en = 1'b1; bus.wr_pair_sel = 2'd1; bus.wr_pair_data = 16'h1122; tick();
    bus.wr_pair_en = 1'b1; bus.wr_pair_sel = 2'd2; bus.wr_pair_data = 16'h3344; tick();
    bus.ex_de_hl = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 4'd4; bus.wr_data = 8'h55; tick();
    check("coll_de",   bus.rd_pair_data,   16'h3344);
    check("coll_conf", 16'(bus.conflict),  16'h0001);
    bus.rd_pair_sel = 2'd2; #1;
    check("coll_hl",   bus.rd_pair_data,   16'h1122);
    tick();
    check("coll_conf_clr", 16'(bus.conflict), 16'h0000);

    // Byte write beats flag update
    bus.wr_en = 1'b1; bus.wr_sel = 4'd1; bus.wr_data = 8'hA5;
    bus.flag_wr_en = 1'b1; bus.flag_data = 8'h00; tick();
    check("f_prio", 16'(bus.f_out), 16'h00A5);

    // Pair write in the EXX cycle lands in the outgoing bank
    bus.rd_pair_sel = 2'd0;
    bus.exx = 1'b1; bus.wr_pair_en = 1'b1; bus.wr_pair_sel = 2'd0; bus.wr_pair_data = 16'h7788; tick();
    check("exx_bc_new", bus.rd_pair_data,  16'h0000);
    check("exx_bmain",  16'(bus.bank_main), 16'h0001);
    bus.exx = 1'b1; tick();
    check("exx_bc_old", bus.rd_pair_data,  16'h7788);

    // Byte and pair to the same register: byte wins, no conflict
    bus.wr_en = 1'b1; bus.wr_sel = 4'd2; bus.wr_data = 8'h99;
    bus.wr_pair_en = 1'b1; bus.wr_pair_sel = 2'd0; bus.wr_pair_data = 16'h1234; tick();
    check("bp_bc",   bus.rd_pair_data,  16'h9934);
    check("bp_conf", 16'(bus.conflict), 16'h0000);

    // Pair write to DE during EX DE,HL is dropped whole
    bus.rd_pair_sel = 2'd1;
    bus.ex_de_hl = 1'b1; bus.wr_pair_en = 1'b1; bus.wr_pair_sel = 2'd1; bus.wr_pair_data = 16'hCAFE; tick();
    check("pdrop_de",   bus.rd_pair_data,  16'h1122);
    check("pdrop_conf", 16'(bus.conflict), 16'h0001);

    // Flag-only update, out-of-range write, and EX DE,HL together with EXX
    bus.flag_wr_en = 1'b1; bus.flag_data = 8'h5A; tick();
    bus.wr_en = 1'b1; bus.wr_sel = 4'd13; bus.wr_data = 8'hAB; tick();
    check("oor_conf", 16'(bus.conflict), 16'h0001);
    bus.rd_a_sel = 4'd13; #1;
    check("oor_read", 16'(bus.rd_a_data), 16'h0000);
    bus.ex_de_hl = 1'b1; bus.exx = 1'b1; tick();
    bus.exx = 1'b1; tick();

    // Asynchronous reset mid-cycle with a pending write
    bus.ex_af = 1'b1; tick();
    bus.rd_a_sel = 4'd0;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd0; bus.wr_data = 8'h77;
    #2;
    rst_L = 1'b0;
    model_reset();
    #1;
    check("arst_a",   16'(bus.a_out),   16'h00FF);
    check("arst_baf", 16'(bus.bank_af), 16'h0000);
    @(posedge clk);
    #1;
    clear_pulses();
    rst_L = 1'b1;
    check("arst_hold", 16'(bus.a_out), 16'h00FF);

    // Unbanked extension registers ignore EXX
    bus.wr_en = 1'b1; bus.wr_sel = 4'd9; bus.wr_data = 8'h5A; tick();
    bus.wr_en = 1'b1; bus.wr_sel = 4'd11; bus.wr_data = 8'hC3; tick();
    bus.exx = 1'b1; tick();
    bus.rd_a_sel = 4'd9; bus.rd_b_sel = 4'd11; #1;
    check("ext9",  16'(bus.rd_a_data), 16'h005A);
    check("ext11", 16'(bus.rd_b_data), 16'h00C3);
    bus.exx = 1'b1; tick();
    sweep();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/z80_regbank.md
Name: z80_regbank

Overview:
- Parametrised Z80 register bank. Replaces the single A / A' pair with full main and alternate banks (A,F,B,C,D,E,H,L and their primes) plus optional unbanked extension registers.
- Provides two byte read ports, one pair read port, one byte write port, one pair write port and a dedicated flag write port.
- Supports the exchanges EX AF,AF' / EXX / EX DE,HL.
- Sits between the control FSM and the ALU/bus muxing in the datapath.

Parameters:
- DW, 8, data width of one register.
- NREG, 8, logical registers per bank. Must be >= 8. Indices 0..7 = A,F,B,C,D,E,H,L (banked). Indices 8..NREG-1 are unbanked extras, e.g. IXH/IXL/IYH/IYL.
- AW, $clog2(NREG), register select width (derived).
- A_RST, all ones, reset value of A and A'.
- F_RST, all ones, reset value of F and F'.

Ports:
- clk  in  1  clock, rising edge
- rst_L  in  1  asynchronous, active-low reset
- rd_a_sel  in  AW  read port A select
- rd_a_data  out  DW  read port A data
- rd_b_sel  in  AW  read port B select
- rd_b_data  out  DW  read port B data
- rd_pair_sel  in  2  pair select: 0=BC, 1=DE, 2=HL, 3=AF
- rd_pair_data  out  2*DW  {high,low} of the selected pair
- wr_en  in  1  byte write enable
- wr_sel  in  AW  byte write target
- wr_data  in  DW  byte write data
- wr_pair_en  in  1  pair write enable
- wr_pair_sel  in  2  pair write target, same encoding as rd_pair_sel
- wr_pair_data  in  2*DW  pair write data
- flag_wr_en  in  1  flag update enable
- flag_data  in  DW  new F value
- ex_af  in  1  EX AF,AF'
- exx  in  1  EXX
- ex_de_hl  in  1  EX DE,HL
- a_out  out  DW  active A, always visible
- f_out  out  DW  active F, always visible
- bank_af  out  1  0 = AF active, 1 = AF' active
- bank_main  out  1  0 = BC/DE/HL active, 1 = primes active
- conflict  out  1  registered pulse: a same-cycle write was dropped

Behaviour:
- Reset (async, rst_L low):
  - A and A' = A_RST; F and F' = F_RST.
  - All other registers = 0.
  - bank_af = 0, bank_main = 0, conflict = 0.
- Reads are combinational and show pre-edge state. There is no write-to-read bypass; a write becomes visible the cycle after its edge.
- Banking is done by pointer, not by data movement:
  - ex_af toggles bank_af at the edge.
  - exx toggles bank_main at the edge.
  - Indices 0-1 map through bank_af; indices 2-7 map through bank_main; indices >= 8 ignore both.
- ex_de_hl physically swaps D<->H and E<->L in the currently active main bank (pre-edge bank_main) in a single cycle.
- Same-cycle ex_af and exx both toggle. ex_de_hl combined with exx swaps within the pre-toggle bank.
- Write address resolution:
  - All writes (byte, pair, flag) resolve the physical register using the pre-edge bank bits.
  - A write in the same cycle as a toggle therefore lands in the bank being switched away from.
- Write priority per physical register, highest first:
  1. wr_en
  2. wr_pair_en
  3. flag_wr_en (F only)
  4. ex_de_hl swap
  5. hold
- ex_de_hl conflicts: any byte or pair write targeting D, E, H or L in the same cycle as ex_de_hl is dropped entirely, including both halves of a DE/HL pair write, and the swap still occurs. conflict = 1 for exactly the next cycle. Writes to other registers proceed normally.
- Byte and pair writes to the same register in the same cycle: the byte write wins for that byte; the other byte of the pair is still written. conflict is not raised.
- Out-of-range selects (sel >= NREG):
  - Reads return 0.
  - Writes are ignored and raise conflict.
- Pair order: the high byte is the first-named register (B, D, H, A).

Decomposition:
- Shared package z80_pkg holds:
  - Register index localparams REG_A..REG_L.
  - Pair encoding enum pair_t {PAIR_BC, PAIR_DE, PAIR_HL, PAIR_AF}.
  - Reset constants.
- One sub-module, z80_reg_bank. It is instantiated twice (main, alt) and holds 8 DW-bit registers with per-register enable/data inputs.
- Mapping, priority and conflict logic live in the top. Extra unbanked registers are a generate array in the top.

Test Plan:
- Reset, then read all selects: A = 0xFF, F = 0xFF, B..L = 0x00, bank_af = 0, bank_main = 0.
- Write A = 0x12, pulse ex_af, write A = 0x34, pulse ex_af. Result: A reads 0x12 and bank_af = 0; after one more ex_af, A reads 0x34.
- Pair-write HL = 0xBEEF, pulse exx, read HL = 0x0000. Pulse exx again, then ex_de_hl. Result: DE = 0xBEEF, HL = 0x0000.
- Same cycle: ex_de_hl plus wr_en to D with 0x55, where DE = 0x1122 and HL = 0x3344. Result: DE = 0x3344, HL = 0x1122, conflict high for one cycle only.
- Same cycle: wr_en F = 0xA5 and flag_wr_en 0x00. Result: F = 0xA5. Then exx plus wr_pair BC = 0x7788 in one cycle: the pre-toggle bank's BC = 0x7788 and the new bank's BC is unchanged.
- Assert rst_L low mid-cycle while wr_en is active: outputs reset immediately without waiting for a clock edge, and the pending write is lost. NREG = 12 build: write index 9 = 0x5A, toggle exx, index 9 still reads 0x5A.
